// File: rtl/lstm_index_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_index_sequencer                                                 |
// | Emits a burst of consecutive element indices under valid/ready, with |
// | group-boundary and final-beat flags for the MATMUL modulus selector. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lstm_index_sequencer #(
   parameter int WIDTH     = 16,
   parameter int MOD       = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base_addr,
   input  logic [WIDTH-1:0] length,
   input  logic             out_ready,
   output logic             idx_valid,
   output logic [WIDTH-1:0] idx_out,
   output logic             group_last,
   output logic             last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [SEL_WIDTH-1:0] C_GRP_MAX = SEL_WIDTH'(MOD - 1);

   state_t               r_state;
   logic [WIDTH-1:0]     r_rem;
   logic [SEL_WIDTH-1:0] r_grp;
   logic [SEL_WIDTH-1:0] w_grp_nxt;
   logic                 w_xfer;
   logic                 w_rem_two;

   assign w_grp_nxt = r_grp + SEL_WIDTH'(1);
   assign w_xfer    = (r_state == S_RUN) && out_ready;
   assign w_rem_two = (r_rem == WIDTH'(2));

   // Valid, busy and done are pure decodes of the registered state.
   assign idx_valid = (r_state == S_RUN);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rem      <= '0;
         r_grp      <= '0;
         idx_out    <= '0;
         group_last <= 1'b0;
         last       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_grp <= '0;
                  if (length == '0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state    <= S_RUN;
                     idx_out    <= base_addr;
                     r_rem      <= length;
                     last       <= (length == WIDTH'(1));
                     group_last <= (length == WIDTH'(1)) || (C_GRP_MAX == '0);
                  end
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  if (last) begin
                     r_state    <= S_DONE;
                     last       <= 1'b0;
                     group_last <= 1'b0;
                  end else begin
                     // Flags are precomputed for the beat that follows this one.
                     idx_out    <= idx_out + WIDTH'(1);
                     r_rem      <= r_rem - WIDTH'(1);
                     r_grp      <= w_grp_nxt;
                     last       <= w_rem_two;
                     group_last <= (w_grp_nxt == C_GRP_MAX) || w_rem_two;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/lstm_index_sequencer.md
# lstm_index_sequencer

Generates the element-index stream feeding the MATMUL modulus selector. On a start pulse it emits `length` consecutive indices from `base_addr`, one per accepted beat, under a valid/ready handshake. It also flags group boundaries every MOD beats and the final beat. Downstream, the modulus selector derives its bank select from `idx_out`; the group flags let the consumer close each MOD-wide vector.

## Interface
- `WIDTH`, 16: width of indices and of the length count.
- `MOD`, 4: group size in beats; must be a power of 2.
- `SEL_WIDTH`, 2: log2(MOD); width of the in-group beat counter.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a burst. Sampled only in IDLE.
- `base_addr` in WIDTH: first index of the burst. Captured when `start` is accepted.
- `length` in WIDTH: number of beats in the burst. Captured when `start` is accepted.
- `out_ready` in 1: consumer can accept a beat.
- `idx_valid` out 1: `idx_out` holds a valid beat.
- `idx_out` out WIDTH: current index.
- `group_last` out 1: the current beat is the MOD-th beat of its group, or the final beat of the burst.
- `last` out 1: the current beat is the final beat of the burst.
- `busy` out 1: the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when the burst completes.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 with `length`≠0: capture `base_addr` and `length`, clear the beat counters, go to RUN.
  - `start`=1 with `length`=0: go to DONE directly. No beats are emitted.
- **RUN:**
  - `idx_valid`=1.
  - A beat transfers when `idx_valid` & `out_ready`.
  - On each transfer: `idx_out` increments by 1, the remaining count decrements, and the in-group counter increments.
  - `idx_out` wraps modulo 2^WIDTH (0xFFFF → 0x0000 for WIDTH=16). Wrap does not end the burst.
  - `group_last` = (in-group counter == MOD-1) OR `last`. The in-group counter is relative to burst start, not to the index value. It wraps to 0 after MOD-1 and is reset to 0 on each start.
  - `last` = (remaining count == 1).
  - When the transfer with `last`=1 completes, go to DONE.
- **DONE:** `done`=1 and `idx_valid`=0 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- `busy`=1 in RUN and DONE.
- `length` is unsigned; max burst is 2^WIDTH-1 beats.

## Timing
- Reset: state IDLE, and `idx_valid`, `group_last`, `last`, `busy`, `done` all =0, `idx_out`=0. The internal counters are also cleared.
- Start latency: `start` is sampled high in IDLE at edge N. From cycle N+1, `idx_valid`=1 and `idx_out`=`base_addr`.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: while `idx_valid`=1 and `out_ready`=0, `idx_out`, `group_last` and `last` hold stable. `idx_valid` is never dropped mid-burst.
- Completion: the last beat transfers at edge M. `done`=1 in cycle M+1, and IDLE holds from cycle M+2, where a new `start` is accepted.
- Zero length: `start` at edge N gives `done`=1 in cycle N+1, with no valid beats.
- Outputs are registered; there is no combinational path from `out_ready` to `idx_out`. `idx_valid` is a state decode.
- Reset asserted mid-burst: at the next edge, return to the reset values above. No `done` pulse is generated, and the remaining beats are discarded.
- `start` held high across DONE→IDLE: it is accepted in the first IDLE cycle.

## Test plan
- Basic burst: base=93, length=6, `out_ready`=1.
  - Indices 93, 94, 95, 96, 97, 98 on consecutive cycles.
  - `group_last` on 96 (4th beat) and on 98 (last).
  - `last` on 98.
  - `done` one cycle after the 98 transfer.
- Backpressure: base=10, length=4, `out_ready` toggled 1,0,0,1,1,0,1.
  - Exactly 10, 11, 12, 13 transferred.
  - Values are held while stalled, with no duplicates or skips.
  - `done` after 13.
- Wrap-around: base=0xFFFE, length=4, WIDTH=16.
  - Indices FFFE, FFFF, 0000, 0001.
  - `group_last` and `last` on 0001.
  - `busy` stays 1 through the wrap.
- Zero length and ignored start:
  - length=0 gives `done` the next cycle with `idx_valid` never asserted.
  - A second `start` pulsed during a length=8 burst is ignored: 8 beats, one `done`.
- Reset mid-burst: assert `rst` after the 3rd beat of a length=8 burst.
  - Next cycle: `idx_valid`=0, `busy`=0, `done`=0, `idx_out`=0.
  - A fresh start (base=0, length=2) then emits 0, 1 with `group_last` on 1.
